// File: rtl/execute_issue_ctrl_pkg.sv
// execute_issue_ctrl_pkg: shared FSM encoding, opcode classification and field widths
package execute_issue_ctrl_pkg;
    localparam int OP_W         = 6;
    localparam int RD_W         = 5;
    localparam int MULTI_OP_MIN = 20;
    localparam int MULTI_OP_MAX = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    function automatic logic is_multi_op(input logic [OP_W-1:0] op);
        return (op >= OP_W'(MULTI_OP_MIN)) && (op <= OP_W'(MULTI_OP_MAX));
    endfunction
endpackage

// File: rtl/execute_issue_ctrl_if.sv
// execute_issue_ctrl_if: decode/execute/memory-stage handshake bundle for the issue controller
//   slave  : the controller (consumes decode + execute-unit signals, drives stall/start/result)
//   master : the surrounding pipeline / testbench
interface execute_issue_ctrl_if
    import execute_issue_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic                  issue_valid_i;
    logic [OP_W-1:0]       ALU_operation_i;
    logic [RD_W-1:0]       rd_i;
    logic                  reg_write_i;
    logic                  flush_i;
    logic                  exec_ready_o_i;
    logic                  exec_valid_result_i;
    logic [DATA_WIDTH-1:0] exec_result_i;
    logic                  exec_ready_i_o;
    logic                  stall_o;
    logic                  result_valid_o;
    logic [DATA_WIDTH-1:0] result_o;
    logic [RD_W-1:0]       rd_o;
    logic                  reg_write_o;
    logic                  timeout_err_o;

    modport slave (
        input  issue_valid_i, ALU_operation_i, rd_i, reg_write_i, flush_i,
               exec_ready_o_i, exec_valid_result_i, exec_result_i,
        output exec_ready_i_o, stall_o, result_valid_o, result_o, rd_o,
               reg_write_o, timeout_err_o
    );

    modport master (
        output issue_valid_i, ALU_operation_i, rd_i, reg_write_i, flush_i,
               exec_ready_o_i, exec_valid_result_i, exec_result_i,
        input  exec_ready_i_o, stall_o, result_valid_o, result_o, rd_o,
               reg_write_o, timeout_err_o
    );
endinterface

// File: rtl/exec_timeout_counter.sv
// exec_timeout_counter: watchdog counting cycles spent waiting on the execute unit
//   clock, reset (sync, active-low)
//   clear    : restart the count (asserted on the edge that enters a waiting state)
//   count_en : currently in a waiting state
//   expired  : this cycle's edge brings the count to LIMIT
module exec_timeout_counter #(
    parameter int LIMIT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (count_en)
            count <= count + 1'b1;
    end

    assign expired = count_en && (count == W'(LIMIT - 1));
endmodule

// File: rtl/execute_issue_ctrl.sv
// execute_issue_ctrl: issues single/multi-cycle ops to the execute unit, stalls decode and strobes results
//   clock, reset (sync, active-low)
//   bus  : execute_issue_ctrl_if.slave -- decode inputs, execute-unit handshake, registered result outputs
//   scan : print one status line per cycle, tagged with CORE
//   EXEC_ISSUE_TIMEOUT_EN : when defined, a watchdog aborts WAIT/DRAIN after TIMEOUT_CYCLES
//                           and sets the sticky timeout_err_o
module execute_issue_ctrl
    import execute_issue_ctrl_pkg::*;
#(
    parameter int CORE           = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                  clock,
    input logic                  reset,
    execute_issue_ctrl_if.slave  bus,
    input logic                  scan
);
    state_t                state, state_nx;
    logic                  stall_c, start_c, capture, timeout_hit, timeout_err;
    logic                  rv_q, rw_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [RD_W-1:0]       rd_q;

    // The watchdog abort wins in WAIT/DRAIN: once it fires nothing is owed any more.
    always_comb begin
        state_nx = state;
        stall_c  = 1'b0;
        start_c  = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: if (!bus.flush_i && bus.issue_valid_i) begin
                if (is_multi_op(bus.ALU_operation_i)) begin
                    stall_c  = 1'b1;
                    start_c  = bus.exec_ready_o_i;
                    state_nx = bus.exec_ready_o_i ? WAIT : ISSUE;
                end else
                    capture = 1'b1;
            end
            ISSUE: if (bus.flush_i)
                state_nx = IDLE;
            else begin
                stall_c  = 1'b1;
                start_c  = bus.exec_ready_o_i;
                state_nx = bus.exec_ready_o_i ? WAIT : ISSUE;
            end
            WAIT: begin
                stall_c = 1'b1;
                if (timeout_hit)
                    state_nx = IDLE;
                else if (bus.flush_i)
                    state_nx = DRAIN;
                else if (bus.exec_valid_result_i) begin
                    capture  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            DRAIN: begin
                // The killed op's result is still owed; swallow it before accepting new work.
                stall_c  = bus.issue_valid_i;
                state_nx = (bus.exec_valid_result_i || timeout_hit) ? IDLE : DRAIN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // rv_q follows capture, so a multi-cycle result strobes exactly in DONE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            rv_q     <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
        end else begin
            state <= state_nx;
            rv_q  <= capture;
            if (capture) begin
                result_q <= bus.exec_result_i;
                rd_q     <= bus.rd_i;
                rw_q     <= bus.reg_write_i;
            end
        end
    end

`ifdef EXEC_ISSUE_TIMEOUT_EN
    logic in_wd, wd_entry;

    assign in_wd    = (state == WAIT) || (state == DRAIN);
    assign wd_entry = ((state_nx == WAIT) || (state_nx == DRAIN)) && (state_nx != state);

    exec_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .clear    (wd_entry),
        .count_en (in_wd),
        .expired  (timeout_hit)
    );

    always_ff @(posedge clock) begin
        if (!reset)
            timeout_err <= 1'b0;
        else if (timeout_hit)
            timeout_err <= 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign bus.exec_ready_i_o = reset & start_c;
    assign bus.stall_o        = reset & stall_c;
    assign bus.result_valid_o = rv_q;
    assign bus.result_o       = result_q;
    assign bus.rd_o           = rd_q;
    assign bus.reg_write_o    = rw_q;
    assign bus.timeout_err_o  = timeout_err;

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (scan)
            $display("core %0d: state=%s stall=%b result_valid=%b result=%h",
                     CORE, state.name(), bus.stall_o, bus.result_valid_o, bus.result_o);
    end
`endif
endmodule

// File: tb/tb_execute_issue_ctrl.sv
// tb_execute_issue_ctrl: table-driven directed check of execute_issue_ctrl plus watchdog sequences
module tb_execute_issue_ctrl;
    typedef struct {
        logic        rst;
        logic        iv;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic        rw;
        logic        fl;
        logic        rdy;
        logic        vr;
        logic [31:0] res;
        logic        e_stall;
        logic        e_start;
        logic        e_rv;
        logic [31:0] e_res;
        logic [4:0]  e_rd;
        logic        e_rw;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic scan  = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t tv[$];

    always #5 clock = ~clock;

    execute_issue_ctrl_if #(.DATA_WIDTH(32)) bus ();

    execute_issue_ctrl #(
        .CORE           (0),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave),
        .scan  (scan)
    );

    function automatic vec_t mk(logic rst, logic iv, logic [5:0] op, logic [4:0] rd, logic rw,
                                logic fl, logic rdy, logic vr, logic [31:0] res,
                                logic e_stall, logic e_start, logic e_rv, logic [31:0] e_res,
                                logic [4:0] e_rd, logic e_rw);
        vec_t v;
        v.rst = rst; v.iv = iv; v.op = op; v.rd = rd; v.rw = rw; v.fl = fl; v.rdy = rdy;
        v.vr = vr; v.res = res; v.e_stall = e_stall; v.e_start = e_start; v.e_rv = e_rv;
        v.e_res = e_res; v.e_rd = e_rd; v.e_rw = e_rw;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(negedge clock);
        reset                   = v.rst;
        bus.issue_valid_i       = v.iv;
        bus.ALU_operation_i     = v.op;
        bus.rd_i                = v.rd;
        bus.reg_write_i         = v.rw;
        bus.flush_i             = v.fl;
        bus.exec_ready_o_i      = v.rdy;
        bus.exec_valid_result_i = v.vr;
        bus.exec_result_i       = v.res;
        #2;
    endtask

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // reset held with a multi op presented: comb outputs forced low
        tv.push_back(mk(0,1,20,0,0,0,1,0,0,       0,0,0,0,0,0));
        // single-cycle ADD
        tv.push_back(mk(1,1,0,3,1,0,0,0,5,        0,0,0,0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,0,0,'h77,     0,0,1,5,3,1));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,        0,0,0,5,3,1));
        // MUL, ready immediately, result 4 cycles later; issue in DONE ignored
        tv.push_back(mk(1,1,20,7,1,0,1,0,0,       1,1,0,5,3,1));
        tv.push_back(mk(1,1,20,7,1,0,1,0,0,       1,0,0,5,3,1));
        tv.push_back(mk(1,1,20,7,1,0,1,0,0,       1,0,0,5,3,1));
        tv.push_back(mk(1,1,20,7,1,0,1,0,0,       1,0,0,5,3,1));
        tv.push_back(mk(1,1,20,7,1,0,1,1,'h1234,  1,0,0,5,3,1));
        tv.push_back(mk(1,1,0,9,0,0,0,0,'hAB,     0,0,1,'h1234,7,1));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,        0,0,0,'h1234,7,1));
        // DIV, execute unit busy for 3 cycles
        tv.push_back(mk(1,1,24,2,1,0,0,0,0,       1,0,0,'h1234,7,1));
        tv.push_back(mk(1,1,24,2,1,0,0,0,0,       1,0,0,'h1234,7,1));
        tv.push_back(mk(1,1,24,2,1,0,0,0,0,       1,0,0,'h1234,7,1));
        tv.push_back(mk(1,1,24,2,1,0,1,0,0,       1,1,0,'h1234,7,1));
        tv.push_back(mk(1,1,24,2,1,0,1,0,0,       1,0,0,'h1234,7,1));
        tv.push_back(mk(1,1,24,2,1,0,1,1,'h99,    1,0,0,'h1234,7,1));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,        0,0,1,'h99,2,1));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,        0,0,0,'h99,2,1));
        // op 32 (upper bound), flush in WAIT, late result drained
        tv.push_back(mk(1,1,32,4,0,0,1,0,0,       1,1,0,'h99,2,1));
        tv.push_back(mk(1,1,32,4,0,1,1,0,0,       1,0,0,'h99,2,1));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,        0,0,0,'h99,2,1));
        tv.push_back(mk(1,1,0,1,1,0,0,1,'hDEAD,   1,0,0,'h99,2,1));
        // back in IDLE: flush together with valid_result in WAIT
        tv.push_back(mk(1,1,20,5,1,0,1,0,0,       1,1,0,'h99,2,1));
        tv.push_back(mk(1,1,20,5,1,1,1,1,'h555,   1,0,0,'h99,2,1));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,        0,0,0,'h99,2,1));
        tv.push_back(mk(1,0,0,0,0,0,0,1,'h666,    0,0,0,'h99,2,1));
        // ops 19 and 33 are single-cycle, back to back
        tv.push_back(mk(1,1,19,6,0,0,0,0,'h42,    0,0,0,'h99,2,1));
        tv.push_back(mk(1,1,33,8,1,0,0,0,'h33,    0,0,1,'h42,6,0));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,        0,0,1,'h33,8,1));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,        0,0,0,'h33,8,1));
        // flush in IDLE kills single and multi ops
        tv.push_back(mk(1,1,0,1,1,1,0,0,'hBAD,    0,0,0,'h33,8,1));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,        0,0,0,'h33,8,1));
        tv.push_back(mk(1,1,20,1,1,1,1,0,0,       0,0,0,'h33,8,1));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,        0,0,0,'h33,8,1));
        // stray valid_result in IDLE
        tv.push_back(mk(1,0,0,0,0,0,0,1,'hEEE,    0,0,0,'h33,8,1));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,        0,0,0,'h33,8,1));
        // reset mid-WAIT, then a late result
        tv.push_back(mk(1,1,25,9,1,0,1,0,0,       1,1,0,'h33,8,1));
        tv.push_back(mk(0,1,25,9,1,0,1,0,0,       0,0,0,'h33,8,1));
        tv.push_back(mk(1,0,0,0,0,0,0,1,'hFFF,    0,0,0,0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,        0,0,0,0,0,0));

        for (int i = 0; i < tv.size(); i++) begin
            scan = (i == 1 || i == 2);
            drive(tv[i]);
            chk("stall", i, 32'(bus.stall_o), 32'(tv[i].e_stall));
            chk("exec_ready_i", i, 32'(bus.exec_ready_i_o), 32'(tv[i].e_start));
            chk("result_valid", i, 32'(bus.result_valid_o), 32'(tv[i].e_rv));
            chk("result", i, bus.result_o, tv[i].e_res);
            chk("rd", i, 32'(bus.rd_o), 32'(tv[i].e_rd));
            chk("reg_write", i, 32'(bus.reg_write_o), 32'(tv[i].e_rw));
            chk("timeout_err", i, 32'(bus.timeout_err_o), 32'd0);
        end
        scan = 1'b0;

`ifdef EXEC_ISSUE_TIMEOUT_EN
        drive(mk(1,1,20,3,1,0,1,0,0, 0,0,0,0,0,0));
        chk("wd_start", 100, 32'(bus.exec_ready_i_o), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            drive(mk(1,1,20,3,1,0,1,0,0, 0,0,0,0,0,0));
            chk("wd_stall", 100 + k, 32'(bus.stall_o), 32'd1);
            chk("wd_err_early", 100 + k, 32'(bus.timeout_err_o), 32'd0);
        end
        drive(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        chk("wd_err", 110, 32'(bus.timeout_err_o), 32'd1);
        chk("wd_idle_stall", 110, 32'(bus.stall_o), 32'd0);
        chk("wd_no_strobe", 110, 32'(bus.result_valid_o), 32'd0);
        drive(mk(1,1,0,4,1,0,0,0,'h11, 0,0,0,0,0,0));
        chk("wd_single_stall", 111, 32'(bus.stall_o), 32'd0);
        drive(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        chk("wd_single_rv", 112, 32'(bus.result_valid_o), 32'd1);
        chk("wd_single_res", 112, bus.result_o, 32'h11);
        chk("wd_err_sticky", 112, 32'(bus.timeout_err_o), 32'd1);
        drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        drive(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        chk("wd_err_reset", 113, 32'(bus.timeout_err_o), 32'd0);
`else
        drive(mk(1,1,20,3,1,0,1,0,0, 0,0,0,0,0,0));
        chk("long_start", 100, 32'(bus.exec_ready_i_o), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            drive(mk(1,1,20,3,1,0,1,0,0, 0,0,0,0,0,0));
            chk("long_stall", 100 + k, 32'(bus.stall_o), 32'd1);
            chk("long_err", 100 + k, 32'(bus.timeout_err_o), 32'd0);
        end
        drive(mk(1,1,20,3,1,0,1,1,'hC0DE, 0,0,0,0,0,0));
        chk("long_last_stall", 121, 32'(bus.stall_o), 32'd1);
        drive(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        chk("long_rv", 122, 32'(bus.result_valid_o), 32'd1);
        chk("long_res", 122, bus.result_o, 32'hC0DE);
        chk("long_rd", 122, 32'(bus.rd_o), 32'd3);
        chk("long_stall_done", 122, 32'(bus.stall_o), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
